// File: rtl/alu_defs.sv
// Shared ALU definitions: opcode encoding and the sequencer FSM state type.
// Both the alu and alu_op_sequencer import this package, so each opcode value
// is defined in exactly one place.
package alu_defs;

    typedef logic [2:0] opcode_t;

    localparam opcode_t ADD = 3'd0;
    localparam opcode_t SUB = 3'd1;
    localparam opcode_t MUL = 3'd2;
    localparam opcode_t DIV = 3'd3;
    localparam opcode_t NOT = 3'd4;
    localparam opcode_t XOR = 3'd5;
    localparam opcode_t OR  = 3'd6;
    localparam opcode_t AND = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for alu_op_sequencer: REG_COUNT x DATA_WIDTH storage with two
// asynchronous read ports and two write ports. The writeback port has priority
// over the external load port when both target the same entry in one cycle.
module alu_regfile #(
    parameter  int DATA_WIDTH = 16,
    parameter  int REG_COUNT  = 8,
    localparam int ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] rf [REG_COUNT];

    // Read ports see the contents before this cycle's writes land.
    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];

    // Storage update: external load first, writeback second so it wins on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every entry is cleared on reset because the architecture promises a zeroed
            // register file; this forces flops rather than a RAM macro, acceptable at this size.
            for (int i = 0; i < REG_COUNT; i++) begin
                rf[i] <= '0;
            end
        end else begin
            // NOTE: with non-blocking assignments the last one scheduled for the same entry takes
            // effect, which is exactly how the writeback priority is expressed here.
            if (wr_en) begin
                rf[wr_addr] <= wr_data;
            end
            if (wb_en) begin
                rf[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the ALU interface. Accepts a register-
// addressed command, reads both operands from the local register file, drives
// registered oc/a/b into the external combinational alu, captures f, writes it
// back to the destination register and offers it on a valid/ready channel.
// Optional feature macro ALU_SEQ_FLAGS_EN adds res_zero and res_div0 outputs.
module alu_op_sequencer
    import alu_defs::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int REG_COUNT  = 8,
    localparam int ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_oc,
    input  logic [ADDR_W-1:0]     cmd_dst,
    input  logic [ADDR_W-1:0]     cmd_src_a,
    input  logic [ADDR_W-1:0]     cmd_src_b,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [2:0]            alu_oc,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_f,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                  res_zero,
    output logic                  res_div0,
`endif
    output logic [ADDR_W-1:0]     res_dst
);

    state_t                state;
    logic [ADDR_W-1:0]     dst;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  wb_en;

    // Commands are accepted only from IDLE; no look-ahead, so at most one per 3 cycles.
    assign cmd_ready = (state == IDLE);

    // The alu result is written back during the single EXEC cycle.
    assign wb_en = (state == EXEC);

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (cmd_src_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (cmd_src_b),
        .rd_data_b (rd_data_b),
        .wb_en     (wb_en),
        .wb_addr   (dst),
        .wb_data   (alu_f),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Command FSM with registered alu drive and result channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dst       <= '0;
            alu_oc    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_dst   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero  <= 1'b0;
            res_div0  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_oc <= cmd_oc;
                        alu_a  <= rd_data_a;
                        alu_b  <= rd_data_b;
                        dst    <= cmd_dst;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_f;
                    res_dst   <= dst;
                    res_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                    res_zero  <= (alu_f == '0);
                    res_div0  <= (alu_oc == DIV) && (alu_b == '0);
`endif
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
